// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: ALU opcode encodings, requester count
// and the round-robin pointer type.
package alu_arbiter_pkg;

    localparam int ARB_NREQ = 2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_EQ   = 4'd8;
    localparam logic [3:0] ALU_NE   = 4'd9;
    localparam logic [3:0] ALU_LT   = 4'd10;
    localparam logic [3:0] ALU_LTU  = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;
    localparam logic [3:0] ALU_JALR = 4'd14;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle for both requesters of the ALU arbiter.
// The requesters drive through master, the arbiter sits on slave.
interface alu_arbiter_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
);
    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [XLEN-1:0] req0_a_i;
    logic [XLEN-1:0] req0_b_i;
    logic [OPW-1:0]  req0_op_i;
    logic            resp0_valid_o;
    logic            resp0_ready_i;
    logic [XLEN-1:0] resp0_result_o;

    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [XLEN-1:0] req1_a_i;
    logic [XLEN-1:0] req1_b_i;
    logic [OPW-1:0]  req1_op_i;
    logic            resp1_valid_o;
    logic            resp1_ready_i;
    logic [XLEN-1:0] resp1_result_o;

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_op_i, resp0_ready_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_op_i, resp1_ready_i,
        input  req0_ready_o, resp0_valid_o, resp0_result_o,
        input  req1_ready_o, resp1_valid_o, resp1_result_o
    );

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_op_i, resp0_ready_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_op_i, resp1_ready_i,
        output req0_ready_o, resp0_valid_o, resp0_result_o,
        output req1_ready_o, resp1_valid_o, resp1_result_o
    );
endinterface

// File: rtl/alu_resp_slot.sv
// Single-entry response register: captures an ALU result on load and holds it
// until the consumer takes it.
module alu_resp_slot #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    // NOTE: result is reset too because it is a visible output with a defined
    // reset value; pure datapath storage nobody observes could skip reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
        end else if (load_i) begin
            valid_o  <= 1'b1;
            result_o <= data_i;
        end else if (ready_i) begin
            valid_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage
// (port 0) and the branch/jump unit (port 1); one issue per cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_arbiter_if.slave    bus,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [OPW-1:0]  alu_op_o,
    input  logic [XLEN-1:0] alu_result_i
);

    port_e rr_ptr;
    logic  elig0, elig1;
    logic  grant0, grant1;

    // A full slot that drains this cycle is free; nothing issues during reset.
    assign elig0 = !rst_i && bus.req0_valid_i && (!bus.resp0_valid_o || bus.resp0_ready_i);
    assign elig1 = !rst_i && bus.req1_valid_i && (!bus.resp1_valid_o || bus.resp1_ready_i);

    assign grant0 = elig0 && (!elig1 || rr_ptr == PORT0);
    assign grant1 = elig1 && (!elig0 || rr_ptr == PORT1);

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;

    // NOTE: every output gets a default before the if-chain, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = OPW'(ALU_ADD);
        if (grant0) begin
            alu_a_o  = bus.req0_a_i;
            alu_b_o  = bus.req0_b_i;
            alu_op_o = bus.req0_op_i;
        end else if (grant1) begin
            alu_a_o  = bus.req1_a_i;
            alu_b_o  = bus.req1_b_i;
            alu_op_o = bus.req1_op_i;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= PORT0;
        end else if (grant0) begin
            rr_ptr <= PORT1;
        end else if (grant1) begin
            rr_ptr <= PORT0;
        end
    end

    alu_resp_slot #(.XLEN(XLEN)) u_slot0 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (grant0),
        .data_i   (alu_result_i),
        .ready_i  (bus.resp0_ready_i),
        .valid_o  (bus.resp0_valid_o),
        .result_o (bus.resp0_result_o)
    );

    alu_resp_slot #(.XLEN(XLEN)) u_slot1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (grant1),
        .data_i   (alu_result_i),
        .ready_i  (bus.resp1_ready_i),
        .valid_o  (bus.resp1_valid_o),
        .result_o (bus.resp1_result_o)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model closing the loop
// between alu_*_o and alu_result_i.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int XLEN = 32;
    localparam int OPW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic [OPW-1:0]  alu_op;
    int              total = 0;
    int              bad   = 0;
    int              cnt0, cnt1;

    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

    alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_res)
    );

    function automatic logic [XLEN-1:0] alu_ref(logic [OPW-1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_EQ:   return {31'd0, a == b};
            ALU_NE:   return {31'd0, a != b};
            ALU_LT:   return {31'd0, $signed(a) < $signed(b)};
            ALU_LTU:  return {31'd0, a < b};
            ALU_GE:   return {31'd0, $signed(a) >= $signed(b)};
            ALU_GEU:  return {31'd0, a >= b};
            ALU_JALR: return (a + b) & ~32'd1;
            default:  return '0;
        endcase
    endfunction

    assign alu_res = alu_ref(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid_i  = 1'b0;
        bus.req0_a_i      = '0;
        bus.req0_b_i      = '0;
        bus.req0_op_i     = ALU_ADD;
        bus.resp0_ready_i = 1'b0;
        bus.req1_valid_i  = 1'b0;
        bus.req1_a_i      = '0;
        bus.req1_b_i      = '0;
        bus.req1_op_i     = ALU_ADD;
        bus.resp1_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset: outputs cleared, no ready while reset is held.
        rst = 1'b1;
        clear_inputs();
        tick();
        bus.req0_valid_i = 1'b1;
        bus.req0_a_i     = 32'd42;
        bus.req0_b_i     = 32'd1337;
        bus.req0_op_i    = ALU_SUB;
        settle();
        check("rst_req0_ready", {31'd0, bus.req0_ready_o}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
        tick();
        check("rst_resp0_valid", {31'd0, bus.resp0_valid_o}, 32'd0);
        check("rst_resp0_result", bus.resp0_result_o, 32'd0);
        check("rst_resp1_valid", {31'd0, bus.resp1_valid_o}, 32'd0);
        check("rst_resp1_result", bus.resp1_result_o, 32'd0);

        // Port 0 alone: ADD(42,1337).
        do_reset();
        bus.req0_valid_i  = 1'b1;
        bus.req0_a_i      = 32'd42;
        bus.req0_b_i      = 32'd1337;
        bus.req0_op_i     = ALU_ADD;
        bus.resp0_ready_i = 1'b1;
        settle();
        check("p0only_req0_ready", {31'd0, bus.req0_ready_o}, 32'd1);
        check("p0only_req1_ready", {31'd0, bus.req1_ready_o}, 32'd0);
        check("p0only_alu_a", alu_a, 32'd42);
        check("p0only_alu_b", alu_b, 32'd1337);
        tick();
        bus.req0_valid_i = 1'b0;
        settle();
        check("p0only_resp0_valid", {31'd0, bus.resp0_valid_o}, 32'd1);
        check("p0only_resp0_result", bus.resp0_result_o, 32'd1379);
        check("p0only_resp1_valid", {31'd0, bus.resp1_valid_o}, 32'd0);
        tick();
        check("p0only_drained", {31'd0, bus.resp0_valid_o}, 32'd0);
        check("p0only_result_hold", bus.resp0_result_o, 32'd1379);

        // Both valid right after reset: p0 first, then p1.
        do_reset();
        bus.req0_valid_i  = 1'b1;
        bus.req0_a_i      = 32'd42;
        bus.req0_b_i      = 32'd1337;
        bus.req0_op_i     = ALU_ADD;
        bus.req1_valid_i  = 1'b1;
        bus.req1_a_i      = 32'd42;
        bus.req1_b_i      = 32'd1337;
        bus.req1_op_i     = ALU_SUB;
        bus.resp0_ready_i = 1'b1;
        bus.resp1_ready_i = 1'b1;
        settle();
        check("both_c0_req0_ready", {31'd0, bus.req0_ready_o}, 32'd1);
        check("both_c0_req1_ready", {31'd0, bus.req1_ready_o}, 32'd0);
        tick();
        bus.req0_valid_i = 1'b0;
        settle();
        check("both_c1_resp0_result", bus.resp0_result_o, 32'd1379);
        check("both_c1_req1_ready", {31'd0, bus.req1_ready_o}, 32'd1);
        check("both_c1_alu_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
        tick();
        bus.req1_valid_i = 1'b0;
        settle();
        check("both_c2_resp1_valid", {31'd0, bus.resp1_valid_o}, 32'd1);
        check("both_c2_resp1_result", bus.resp1_result_o, 32'hFFFFFAF1);

        // Full contention for 6 cycles: strict alternation, 3 responses each.
        do_reset();
        bus.req0_valid_i  = 1'b1;
        bus.req0_a_i      = 32'd1;
        bus.req0_b_i      = 32'd2;
        bus.req0_op_i     = ALU_ADD;
        bus.req1_valid_i  = 1'b1;
        bus.req1_a_i      = 32'd6;
        bus.req1_b_i      = 32'd3;
        bus.req1_op_i     = ALU_XOR;
        bus.resp0_ready_i = 1'b1;
        bus.resp1_ready_i = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("rr_c%0d_req0_ready", i), {31'd0, bus.req0_ready_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_c%0d_req1_ready", i), {31'd0, bus.req1_ready_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (i == 5) begin
                bus.req0_valid_i = 1'b0;
                bus.req1_valid_i = 1'b0;
            end
            if (bus.resp0_valid_o) begin
                cnt0++;
                check("rr_resp0_result", bus.resp0_result_o, 32'd3);
            end
            if (bus.resp1_valid_o) begin
                cnt1++;
                check("rr_resp1_result", bus.resp1_result_o, 32'd5);
            end
        end
        check("rr_cnt0", cnt0, 32'd3);
        check("rr_cnt1", cnt1, 32'd3);

        // Backpressure on port 0 while port 1 keeps being served.
        do_reset();
        bus.req0_valid_i  = 1'b1;
        bus.req0_a_i      = 32'd42;
        bus.req0_b_i      = 32'd1337;
        bus.req0_op_i     = ALU_LTU;
        bus.req1_valid_i  = 1'b1;
        bus.req1_a_i      = 32'd5;
        bus.req1_b_i      = 32'd5;
        bus.req1_op_i     = ALU_EQ;
        bus.resp0_ready_i = 1'b0;
        bus.resp1_ready_i = 1'b1;
        settle();
        check("bp_c0_req0_ready", {31'd0, bus.req0_ready_o}, 32'd1);
        check("bp_c0_req1_ready", {31'd0, bus.req1_ready_o}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("bp_c%0d_resp0_valid", c), {31'd0, bus.resp0_valid_o}, 32'd1);
            check($sformatf("bp_c%0d_resp0_result", c), bus.resp0_result_o, 32'd1);
            check($sformatf("bp_c%0d_req0_ready", c), {31'd0, bus.req0_ready_o}, 32'd0);
            check($sformatf("bp_c%0d_req1_ready", c), {31'd0, bus.req1_ready_o}, 32'd1);
            if (c >= 2) begin
                check($sformatf("bp_c%0d_resp1_valid", c), {31'd0, bus.resp1_valid_o}, 32'd1);
                check($sformatf("bp_c%0d_resp1_result", c), bus.resp1_result_o, 32'd1);
            end
        end
        bus.resp0_ready_i = 1'b1;
        settle();
        check("bp_drain_req0_ready", {31'd0, bus.req0_ready_o}, 32'd1);
        check("bp_drain_req1_ready", {31'd0, bus.req1_ready_o}, 32'd0);
        tick();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        settle();
        check("bp_reload_resp0_valid", {31'd0, bus.resp0_valid_o}, 32'd1);
        check("bp_reload_resp0_result", bus.resp0_result_o, 32'd1);
        check("bp_reload_resp1_valid", {31'd0, bus.resp1_valid_o}, 32'd0);

        // JALR on port 1, then reset lands while it is still requesting.
        do_reset();
        bus.req1_valid_i  = 1'b1;
        bus.req1_a_i      = 32'd4;
        bus.req1_b_i      = 32'hFFFFFFFE;
        bus.req1_op_i     = ALU_JALR;
        bus.resp1_ready_i = 1'b1;
        settle();
        check("jalr_req1_ready", {31'd0, bus.req1_ready_o}, 32'd1);
        check("jalr_alu_op", {28'd0, alu_op}, {28'd0, ALU_JALR});
        check("jalr_alu_b", alu_b, 32'hFFFFFFFE);
        tick();
        rst = 1'b1;
        settle();
        check("jalr_resp1_result", bus.resp1_result_o, 32'd2);
        check("jalr_rst_req1_ready", {31'd0, bus.req1_ready_o}, 32'd0);
        check("jalr_rst_alu_a", alu_a, 32'd0);
        check("jalr_rst_alu_b", alu_b, 32'd0);
        check("jalr_rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
        tick();
        check("jalr_after_rst_resp1_valid", {31'd0, bus.resp1_valid_o}, 32'd0);
        check("jalr_after_rst_resp1_result", bus.resp1_result_o, 32'd0);
        rst = 1'b0;
        bus.req0_valid_i = 1'b1;
        bus.req0_a_i     = 32'd7;
        bus.req0_b_i     = 32'd8;
        bus.req0_op_i    = ALU_ADD;
        settle();
        check("post_rst_req0_priority", {31'd0, bus.req0_ready_o}, 32'd1);
        check("post_rst_req1_wait", {31'd0, bus.req1_ready_o}, 32'd0);
        tick();
        clear_inputs();
        settle();
        check("post_rst_resp0_result", bus.resp0_result_o, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
